// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch/execute sequencer for the 16-bit program counter. It loads the
//   reset vector, then loops: fetch opcode, let the decoder see it, fetch
//   0-2 operand bytes, hold the instruction for execute, apply any jump.
//   It is the only driver of the counter's count-enable and jump inputs and
//   it owns the memory read request while fetching.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   pc_addr         current program counter value
//   pc_inc          count-enable to the program counter (combinational)
//   pc_jump         jump strobe to the program counter (combinational)
//   pc_jump_addr    jump target, zero whenever pc_jump is low
//   bus_req         memory read request (combinational)
//   bus_addr        read address
//   mem_ready       read data valid this cycle
//   mem_rdata       read data
//   op_len          operand byte count from the decoder (3 counts as 2)
//   ir, operand     opcode and operand registers ({hi, lo})
//   instr_valid     high for the whole EXEC state
//   exec_done       execute finished this cycle
//   exec_jump       with exec_done: load exec_target into the PC
//   exec_target     control-transfer target
//   state           current FSM state, for debug
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_addr,
    output logic        pc_inc,
    output logic        pc_jump,
    output logic [15:0] pc_jump_addr,
    output logic        bus_req,
    output logic [15:0] bus_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    input  logic [1:0]  op_len,
    output logic [7:0]  ir,
    output logic [15:0] operand,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        exec_jump,
    input  logic [15:0] exec_target,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        RST_LO   = 3'd0,
        RST_HI   = 3'd1,
        FETCH_OP = 3'd2,
        DECODE   = 3'd3,
        FETCH_LO = 3'd4,
        FETCH_HI = 3'd5,
        EXEC     = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  ir_q, ir_d;
    logic [15:0] operand_q, operand_d;
    logic [7:0]  vec_lo_q, vec_lo_d;
    logic        need_hi_q, need_hi_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_LO;
            ir_q      <= '0;
            operand_q <= '0;
            vec_lo_q  <= '0;
            need_hi_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            operand_q <= operand_d;
            vec_lo_q  <= vec_lo_d;
            need_hi_q <= need_hi_d;
        end
    end

    // Next-state and register update logic. In every bus state a read
    // completes only with mem_ready; otherwise everything holds.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        operand_d = operand_q;
        vec_lo_d  = vec_lo_q;
        need_hi_d = need_hi_q;
        case (state_q)
            RST_LO: begin
                if (mem_ready) begin
                    vec_lo_d = mem_rdata;
                    state_d  = RST_HI;
                end
            end
            RST_HI: begin
                if (mem_ready) begin
                    state_d = FETCH_OP;
                end
            end
            FETCH_OP: begin
                if (mem_ready) begin
                    ir_d      = mem_rdata;
                    operand_d = '0;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                // op_len of 2 or 3 both mean two operand bytes
                need_hi_d = op_len[1];
                state_d   = (op_len == 2'd0) ? EXEC : FETCH_LO;
            end
            FETCH_LO: begin
                if (mem_ready) begin
                    operand_d[7:0] = mem_rdata;
                    state_d        = need_hi_q ? FETCH_HI : EXEC;
                end
            end
            FETCH_HI: begin
                if (mem_ready) begin
                    operand_d[15:8] = mem_rdata;
                    state_d         = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    state_d = FETCH_OP;
                end
            end
            default: begin
                state_d = RST_LO;
            end
        endcase
    end

    // Mealy outputs; all held at zero while reset is asserted. pc_inc and
    // pc_jump come from disjoint states so they can never coincide.
    always_comb begin
        pc_inc       = 1'b0;
        pc_jump      = 1'b0;
        pc_jump_addr = '0;
        bus_req      = 1'b0;
        bus_addr     = '0;
        instr_valid  = 1'b0;
        if (!rst) begin
            case (state_q)
                RST_LO: begin
                    bus_req  = 1'b1;
                    bus_addr = RESET_VECTOR;
                end
                RST_HI: begin
                    bus_req  = 1'b1;
                    bus_addr = RESET_VECTOR + 16'd1;
                    if (mem_ready) begin
                        pc_jump      = 1'b1;
                        pc_jump_addr = {mem_rdata, vec_lo_q};
                    end
                end
                FETCH_OP, FETCH_LO, FETCH_HI: begin
                    bus_req  = 1'b1;
                    bus_addr = pc_addr;
                    pc_inc   = mem_ready;
                end
                EXEC: begin
                    instr_valid = 1'b1;
                    if (exec_done && exec_jump) begin
                        pc_jump      = 1'b1;
                        pc_jump_addr = exec_target;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ir      = ir_q;
    assign operand = operand_q;
    assign state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] pc_addr;
    logic        pc_inc;
    logic        pc_jump;
    logic [15:0] pc_jump_addr;
    logic        bus_req;
    logic [15:0] bus_addr;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic [1:0]  op_len;
    logic [7:0]  ir;
    logic [15:0] operand;
    logic        instr_valid;
    logic        exec_done;
    logic        exec_jump;
    logic [15:0] exec_target;
    logic [2:0]  state;

    logic [7:0]  mem [0:65535];
    int          n_checks;
    int          n_errors;
    int          inc_cnt;
    int          both_cnt;
    int          inc_base;

    pc_sequencer #(.RESET_VECTOR(16'hFFFC)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_addr      (pc_addr),
        .pc_inc       (pc_inc),
        .pc_jump      (pc_jump),
        .pc_jump_addr (pc_jump_addr),
        .bus_req      (bus_req),
        .bus_addr     (bus_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .op_len       (op_len),
        .ir           (ir),
        .operand      (operand),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .exec_jump    (exec_jump),
        .exec_target  (exec_target),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External program counter: count-enable has priority over jump
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          pc_addr <= '0;
        else if (pc_inc)  pc_addr <= pc_addr + 16'd1;
        else if (pc_jump) pc_addr <= pc_jump_addr;
    end

    assign mem_rdata = mem[bus_addr];

    // Toy decoder: EA=0 bytes, A9=1, 4C=2, 20=3 (treated as 2)
    always_comb begin
        case (ir)
            8'hA9:   op_len = 2'd1;
            8'h4C:   op_len = 2'd2;
            8'h20:   op_len = 2'd3;
            default: op_len = 2'd0;
        endcase
    end

    // Cycle-level observers, sampled mid-cycle when inputs are stable
    always @(negedge clk) begin
        if (!rst && pc_inc) inc_cnt = inc_cnt + 1;
        if (pc_inc && pc_jump) both_cnt = both_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        inc_cnt   = 0;
        both_cnt  = 0;
        for (int unsigned i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        mem[16'h1234] = 8'hEA;
        mem[16'h1235] = 8'h4C;
        mem[16'h1236] = 8'h00;
        mem[16'h1237] = 8'h80;
        mem[16'h8000] = 8'hA9;
        mem[16'h8001] = 8'h55;
        mem[16'h8002] = 8'h20;
        mem[16'h8003] = 8'h34;
        mem[16'h8004] = 8'h12;
        mem[16'hFFFF] = 8'hEA;

        rst         = 1'b1;
        mem_ready   = 1'b1;
        exec_done   = 1'b0;
        exec_jump   = 1'b0;
        exec_target = 16'h0000;
        step();
        step();
        check_eq("rst_state",   state,   3'd0);
        check_eq("rst_bus_req", bus_req, 1'b0);
        check_eq("rst_addr",    bus_addr, 16'h0000);
        check_eq("rst_ir",      ir,      8'h00);
        check_eq("rst_operand", operand, 16'h0000);

        // Vector load
        rst = 1'b0;
        #1;
        check_eq("vec_lo_state", state, 3'd0);
        check_eq("vec_lo_req",   bus_req, 1'b1);
        check_eq("vec_lo_addr",  bus_addr, 16'hFFFC);
        step();
        check_eq("vec_hi_addr",  bus_addr, 16'hFFFD);
        check_eq("vec_jump",     pc_jump, 1'b1);
        check_eq("vec_jaddr",    pc_jump_addr, 16'h1234);
        step();
        check_eq("vec_fetch_st", state, 3'd2);
        check_eq("vec_fetch_ad", bus_addr, 16'h1234);

        // 1-byte instruction at 1234
        inc_base = inc_cnt;
        step();
        check_eq("nop_decode",   state, 3'd3);
        check_eq("nop_ir",       ir, 8'hEA);
        check_eq("nop_dec_req",  bus_req, 1'b0);
        step();
        check_eq("nop_exec",     state, 3'd6);
        check_eq("nop_valid",    instr_valid, 1'b1);
        check_eq("nop_pc",       pc_addr, 16'h1235);
        check_eq("nop_incs",     inc_cnt - inc_base, 1);
        exec_done = 1'b1;
        #1;
        check_eq("nop_nojump",   pc_jump, 1'b0);
        step();
        exec_done = 1'b0;

        // 3-byte instruction at 1235, then jump to 8000
        inc_base = inc_cnt;
        check_eq("jmp_fetch_ad", bus_addr, 16'h1235);
        step();
        check_eq("jmp_decode",   state, 3'd3);
        step();
        check_eq("jmp_flo",      state, 3'd4);
        step();
        check_eq("jmp_fhi",      state, 3'd5);
        step();
        check_eq("jmp_exec",     state, 3'd6);
        check_eq("jmp_operand",  operand, 16'h8000);
        check_eq("jmp_pc",       pc_addr, 16'h1238);
        check_eq("jmp_incs",     inc_cnt - inc_base, 3);
        exec_done   = 1'b1;
        exec_jump   = 1'b1;
        exec_target = 16'h8000;
        #1;
        check_eq("jmp_pulse",    pc_jump, 1'b1);
        check_eq("jmp_jaddr",    pc_jump_addr, 16'h8000);
        check_eq("jmp_noinc",    pc_inc, 1'b0);
        step();
        exec_done = 1'b0;
        exec_jump = 1'b0;
        check_eq("jmp_next_st",  state, 3'd2);
        check_eq("jmp_next_pc",  pc_addr, 16'h8000);

        // 2-byte instruction with wait states in FETCH_LO
        step();
        step();
        check_eq("ws_flo",       state, 3'd4);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("ws_noinc",  pc_inc, 1'b0);
            check_eq("ws_req",    bus_req, 1'b1);
            step();
            check_eq("ws_hold_st", state, 3'd4);
            check_eq("ws_hold_pc", pc_addr, 16'h8001);
            check_eq("ws_hold_op", operand, 16'h0000);
        end
        mem_ready = 1'b1;
        #1;
        check_eq("ws_inc",       pc_inc, 1'b1);
        step();
        check_eq("ws_exec",      state, 3'd6);
        check_eq("ws_operand",   operand, 16'h0055);
        check_eq("ws_pc",        pc_addr, 16'h8002);

        // exec_jump without exec_done is ignored
        exec_jump   = 1'b1;
        exec_target = 16'h4444;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("ej_nojump", pc_jump, 1'b0);
            step();
            check_eq("ej_state",  state, 3'd6);
        end
        exec_jump = 1'b0;
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check_eq("ej_pc",        pc_addr, 16'h8002);

        // Reset during FETCH_HI
        step();
        step();
        step();
        check_eq("mr_fhi",       state, 3'd5);
        check_eq("mr_partial",   operand, 16'h0034);
        rst = 1'b1;
        #1;
        check_eq("mr_state",     state, 3'd0);
        check_eq("mr_ir",        ir, 8'h00);
        check_eq("mr_operand",   operand, 16'h0000);
        check_eq("mr_req",       bus_req, 1'b0);
        check_eq("mr_inc",       pc_inc, 1'b0);
        check_eq("mr_addr",      bus_addr, 16'h0000);
        check_eq("mr_valid",     instr_valid, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check_eq("mr_vlo_addr",  bus_addr, 16'hFFFC);
        step();
        check_eq("mr_vjaddr",    pc_jump_addr, 16'h1234);
        step();
        check_eq("mr_fetch_ad",  bus_addr, 16'h1234);

        // EA at 1234, jump to FFFF, then wrap on fetch at FFFF
        step();
        step();
        check_eq("wr_exec1",     state, 3'd6);
        exec_done   = 1'b1;
        exec_jump   = 1'b1;
        exec_target = 16'hFFFF;
        step();
        exec_done = 1'b0;
        exec_jump = 1'b0;
        check_eq("wr_fetch_ad",  bus_addr, 16'hFFFF);
        step();
        check_eq("wr_dec_pc",    pc_addr, 16'h0000);
        step();
        check_eq("wr_exec2",     state, 3'd6);
        check_eq("wr_ir",        ir, 8'hEA);
        check_eq("wr_pc",        pc_addr, 16'h0000);

        check_eq("inc_and_jump", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
